avr_tx_arbiter: RTL and testbench

- Shares the single AVR serial transmit channel (tx_data / new_tx_data / tx_busy of the AVR interface) between two byte-stream requesters, e.g. the message printer and a bit-reversal echo path.
- Arbitration is message-granular: once a requester is granted, it owns the channel until it sends a byte flagged last, or until it stalls past a timeout.
- Sits between the requesters and the AVR interface in the top level.

---
 rtl/avr_tx_arbiter.sv | 134 +++++++++++++
 tb/tb_avr_tx_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/avr_tx_arbiter.sv
// Message-granular arbiter sharing the AVR serial TX channel between two byte-stream requesters.
// The owner keeps the channel until it sends a last-flagged byte or idles past TIMEOUT cycles.
module avr_tx_arbiter #(
   parameter int unsigned TIMEOUT = 1000000,
   parameter int unsigned CTR_W   = 20
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req0_data,
   input  logic       req0_valid,
   input  logic       req0_last,
   output logic       req0_ready,
   input  logic [7:0] req1_data,
   input  logic       req1_valid,
   input  logic       req1_last,
   output logic       req1_ready,
   output logic [7:0] tx_data,
   output logic       new_tx_data,
   input  logic       tx_busy,
   output logic [1:0] grant,
   output logic       timeout
);

   localparam int unsigned DATA_W = 8;
   localparam logic [CTR_W-1:0] CTR_LAST = (TIMEOUT == 0) ? '0 : CTR_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_GUARD, S_WAIT} state_e;

   state_e             state_q, state_d;
   logic [1:0]         grant_q, grant_d;
   logic               ptr_q, ptr_d;
   logic [CTR_W-1:0]   ctr_q, ctr_d;
   logic               last_q, last_d;
   logic [DATA_W-1:0]  tx_data_q, tx_data_d;
   logic               new_tx_q, new_tx_d;
   logic               timeout_q, timeout_d;

   logic               sel_valid;
   logic               sel_last;
   logic [DATA_W-1:0]  sel_data;

   // Ready is combinational so the handshake lands in the first ARMED cycle.
   assign req0_ready = (state_q == S_ARMED) & grant_q[0] & ~tx_busy;
   assign req1_ready = (state_q == S_ARMED) & grant_q[1] & ~tx_busy;

   assign sel_valid = grant_q[0] ? req0_valid : req1_valid;
   assign sel_last  = grant_q[0] ? req0_last  : req1_last;
   assign sel_data  = grant_q[0] ? req0_data  : req1_data;

   assign tx_data     = tx_data_q;
   assign new_tx_data = new_tx_q;
   assign grant       = grant_q;
   assign timeout     = timeout_q;

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      ptr_d     = ptr_q;
      ctr_d     = ctr_q;
      last_d    = last_q;
      tx_data_d = tx_data_q;
      new_tx_d  = 1'b0;
      timeout_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (req0_valid | req1_valid) begin
               // ptr_q=0 favours requester 0 on a tie
               if (req0_valid & (~req1_valid | ~ptr_q)) grant_d = 2'b01;
               else                                     grant_d = 2'b10;
               ctr_d   = '0;
               state_d = S_ARMED;
            end
         end
         S_ARMED: begin
            if (sel_valid & ~tx_busy) begin
               tx_data_d = sel_data;
               new_tx_d  = 1'b1;
               last_d    = sel_last;
               ctr_d     = '0;
               state_d   = S_GUARD;
            end else if (~sel_valid && (TIMEOUT != 0)) begin
               if (ctr_q >= CTR_LAST) begin
                  timeout_d = 1'b1;
                  grant_d   = 2'b00;
                  ptr_d     = grant_q[0];
                  ctr_d     = '0;
                  state_d   = S_IDLE;
               end else begin
                  ctr_d = ctr_q + CTR_W'(1);
               end
            end
         end
         S_GUARD: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (~tx_busy) begin
               if (last_q) begin
                  grant_d = 2'b00;
                  ptr_d   = grant_q[0];
                  state_d = S_IDLE;
               end else begin
                  state_d = S_ARMED;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         grant_q   <= 2'b00;
         ptr_q     <= 1'b0;
         ctr_q     <= '0;
         last_q    <= 1'b0;
         tx_data_q <= '0;
         new_tx_q  <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         ptr_q     <= ptr_d;
         ctr_q     <= ctr_d;
         last_q    <= last_d;
         tx_data_q <= tx_data_d;
         new_tx_q  <= new_tx_d;
         timeout_q <= timeout_d;
      end
   end

endmodule

// File: tb/tb_avr_tx_arbiter.sv
// Scoreboard bench for avr_tx_arbiter: expected strobes are queued at stimulus time
// and a negedge monitor pops and compares each new_tx_data strobe.
`timescale 1ns/1ps
module tb_avr_tx_arbiter;

   typedef struct packed {
      logic       src;
      logic [7:0] data;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] rq_data [2];
   logic [1:0] rq_valid;
   logic [1:0] rq_last;
   wire        r0_ready;
   wire        r1_ready;
   wire  [7:0] tx_data;
   wire        new_tx_data;
   wire  [1:0] grant;
   wire        timeout;
   wire        tx_busy;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int busy_len = 0;
   int busy_cnt = 0;
   int strobe_cnt = 0;
   int last_strobe = -1;
   int prev_strobe = -1;
   int to_cnt = 0;
   int to_cyc = -1;
   logic [1:0] to_grant = 2'b11;
   exp_t exp_q[$];

   avr_tx_arbiter #(.TIMEOUT(16), .CTR_W(5)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req0_data   (rq_data[0]),
      .req0_valid  (rq_valid[0]),
      .req0_last   (rq_last[0]),
      .req0_ready  (r0_ready),
      .req1_data   (rq_data[1]),
      .req1_valid  (rq_valid[1]),
      .req1_last   (rq_last[1]),
      .req1_ready  (r1_ready),
      .tx_data     (tx_data),
      .new_tx_data (new_tx_data),
      .tx_busy     (tx_busy),
      .grant       (grant),
      .timeout     (timeout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // AVR interface model: busy for busy_len cycles starting the cycle after a strobe
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)               busy_cnt <= 0;
      else if (new_tx_data)     busy_cnt <= busy_len;
      else if (busy_cnt > 0)    busy_cnt <= busy_cnt - 1;
   end
   assign tx_busy = (busy_cnt != 0);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic push_exp(input logic src, input logic [7:0] d);
      exp_t e;
      e.src  = src;
      e.data = d;
      exp_q.push_back(e);
   endtask

   function automatic logic rdy(input int k);
      return (k == 0) ? r0_ready : r1_ready;
   endfunction

   // Called at a negedge; returns at the negedge after the handshake edge with valid dropped.
   task automatic send_byte(input int k, input logic [7:0] d, input logic l);
      bit done = 1'b0;
      rq_data[k]  = d;
      rq_last[k]  = l;
      rq_valid[k] = 1'b1;
      for (int n = 0; n < 400; n++) begin
         if (rdy(k) === 1'b1) begin
            done = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk($sformatf("handshake_req%0d_%02h", k, d), 32'(done), 32'd1);
      if (done) @(posedge clk);
      @(negedge clk);
      rq_valid[k] = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while ((grant !== 2'b00 || tx_busy) && n < 600) begin
         @(negedge clk);
         n++;
      end
      #1;
      chk(name, 32'(grant), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Monitor: scoreboard pop on strobes, ready legality every cycle, timeout pulse capture
   always @(negedge clk) begin
      if (rst_n) begin
         chk("ready_legal", {30'd0, r1_ready, r0_ready},
             {30'd0, r1_ready & grant[1] & ~tx_busy, r0_ready & grant[0] & ~tx_busy});
         if (new_tx_data) begin
            prev_strobe = last_strobe;
            last_strobe = cyc;
            strobe_cnt++;
            if (exp_q.size() == 0) begin
               chk("strobe_unexpected", {22'd0, grant, tx_data}, 32'hFFFF_FFFF);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("strobe_grant_data", {22'd0, grant, tx_data},
                   {22'd0, (e.src ? 2'b10 : 2'b01), e.data});
            end
         end
         if (timeout) begin
            to_cnt++;
            to_cyc   = cyc;
            to_grant = grant;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, required finish before 1 ms");
      $fatal(1, "watchdog");
   end

   initial begin
      int t_valid;
      int s0;
      rst_n       = 1'b0;
      rq_valid    = 2'b00;
      rq_last     = 2'b00;
      rq_data[0]  = 8'h00;
      rq_data[1]  = 8'h00;
      #1;
      chk("reset_outputs", {20'd0, grant, new_tx_data, timeout, tx_data}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Single two-byte message with a 10-cycle busy interface
      busy_len = 10;
      s0 = strobe_cnt;
      push_exp(1'b0, 8'h48);
      push_exp(1'b0, 8'h69);
      @(negedge clk);
      t_valid = cyc;
      send_byte(0, 8'h48, 1'b0);
      send_byte(0, 8'h69, 1'b1);
      wait_idle("single_msg_release");
      chk("single_strobe_count", 32'(strobe_cnt - s0), 32'd2);
      chk("first_strobe_latency", 32'(prev_strobe - t_valid), 32'd2);
      chk("busy10_strobe_gap", 32'(last_strobe - prev_strobe), 32'd13);

      // Busy held 50 cycles after a strobe
      busy_len = 50;
      push_exp(1'b0, 8'h10);
      push_exp(1'b0, 8'h20);
      @(negedge clk);
      send_byte(0, 8'h10, 1'b0);
      send_byte(0, 8'h20, 1'b1);
      wait_idle("busy_msg_release");
      chk("busy50_strobe_gap", 32'(last_strobe - prev_strobe), 32'd53);

      // Contention after reset: req0 first, req1 next, then req0's second message
      busy_len = 3;
      do_reset();
      s0 = strobe_cnt;
      push_exp(1'b0, 8'hA1);
      push_exp(1'b0, 8'hA2);
      push_exp(1'b1, 8'hB1);
      push_exp(1'b1, 8'hB2);
      push_exp(1'b0, 8'hC1);
      push_exp(1'b0, 8'hC2);
      fork
         begin
            send_byte(0, 8'hA1, 1'b0);
            send_byte(0, 8'hA2, 1'b1);
            send_byte(0, 8'hC1, 1'b0);
            send_byte(0, 8'hC2, 1'b1);
         end
         begin
            send_byte(1, 8'hB1, 1'b0);
            send_byte(1, 8'hB2, 1'b1);
         end
      join
      wait_idle("contention_release");
      chk("contention_strobe_count", 32'(strobe_cnt - s0), 32'd6);
      chk("no_timeout_yet", 32'(to_cnt), 32'd0);

      // Timeout: req0 stalls mid-message, pending req1 takes over
      busy_len = 0;
      push_exp(1'b0, 8'h5A);
      push_exp(1'b1, 8'hC3);
      @(negedge clk);
      send_byte(0, 8'h5A, 1'b0);
      send_byte(1, 8'hC3, 1'b1);
      wait_idle("timeout_recovery_release");
      chk("timeout_pulse_count", 32'(to_cnt), 32'd1);
      chk("timeout_pulse_cycle", 32'(to_cyc - prev_strobe), 32'd18);
      chk("timeout_grant", 32'(to_grant), 32'd0);
      chk("after_timeout_strobe", 32'(last_strobe - prev_strobe), 32'd20);

      // Async reset mid-GUARD; pointer first moved to req1 by a req0 message
      push_exp(1'b0, 8'h11);
      @(negedge clk);
      send_byte(0, 8'h11, 1'b1);
      wait_idle("ptr_setup_release");
      push_exp(1'b1, 8'h22);
      @(negedge clk);
      rq_data[1]  = 8'h22;
      rq_last[1]  = 1'b0;
      rq_valid[1] = 1'b1;
      for (int n = 0; n < 50 && new_tx_data !== 1'b1; n++) @(negedge clk);
      chk("guard_strobe_seen", 32'(new_tx_data), 32'd1);
      rq_valid[1] = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset_outputs", {20'd0, grant, new_tx_data, timeout, tx_data}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      push_exp(1'b0, 8'h33);
      push_exp(1'b1, 8'h44);
      fork
         send_byte(0, 8'h33, 1'b1);
         send_byte(1, 8'h44, 1'b1);
      join
      wait_idle("post_reset_release");

      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      chk("timeout_total", 32'(to_cnt), 32'd1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
